// File: rtl/fetch_pc_unit.sv
// Fetch/PC front end of the 16-bit single-cycle CPU: fetches from a variable-latency
// instruction memory, presents one instruction per EXEC cycle and resolves the next PC.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        branch,
  input  logic        branch_reg,
  input  logic        halt,
  input  logic [2:0]  cond,
  input  logic [15:0] imm,
  input  logic [15:0] rs_data,
  input  logic [2:0]  flag_wen,
  input  logic [2:0]  alu_flags,
  output logic [2:0]  flags,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc;
  logic [7:0]  wait_cnt;
  logic        fetch_timeout;
  logic        cond_taken;
  logic [15:0] branch_target;
  logic [15:0] next_pc;

  // Last permitted miss: this FETCH cycle brings the count up to MAX_WAIT.
  assign fetch_timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  assign imem_addr     = pc;
  assign pc_plus2      = pc + 16'd2;
  assign branch_target = branch_reg ? {rs_data[15:1], 1'b0} : pc_plus2 + imm;
  assign next_pc       = (branch && cond_taken) ? branch_target : pc_plus2;

  // flags = {Z, V, N}; evaluated against the value held before this instruction's write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cond_taken = 1'b0;
    unique case (cond)
      3'b000: cond_taken = !flags[2];
      3'b001: cond_taken = flags[2];
      3'b010: cond_taken = !flags[2] && !flags[0];
      3'b011: cond_taken = flags[0];
      3'b100: cond_taken = flags[2] || (!flags[2] && !flags[0]);
      3'b101: cond_taken = flags[0] || flags[2];
      3'b110: cond_taken = flags[1];
      3'b111: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH: begin
        if (imem_valid)         state_next = EXEC;
        else if (fetch_timeout) state_next = HALTED;
      end
      EXEC:    state_next = halt ? HALTED : FETCH;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == EXEC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= 16'h0000;
      flags     <= 3'b000;
      wait_cnt  <= 8'd0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_valid) begin
            instr    <= imem_rdata;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (fetch_timeout) begin
              fetch_err <= 1'b1;
              halted    <= 1'b1;
            end
          end
        end
        EXEC: begin
          // A halting instruction freezes pc at its own address and suppresses the flag write.
          if (halt) begin
            halted <= 1'b1;
          end else begin
            pc    <= next_pc;
            flags <= (flags & ~flag_wen) | (alu_flags & flag_wen);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit: a driver feeds memory and decoder
// stimulus and queues expectations from a reference model; a monitor checks each EXEC.
module tb_fetch_pc_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic        branch, branch_reg, halt;
  logic [2:0]  cond;
  logic [15:0] imm, rs_data;
  logic [2:0]  flag_wen, alu_flags;
  logic [2:0]  flags;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        fetch_err;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_valid(instr_valid),
    .branch(branch), .branch_reg(branch_reg), .halt(halt),
    .cond(cond), .imm(imm), .rs_data(rs_data),
    .flag_wen(flag_wen), .alu_flags(alu_flags),
    .flags(flags), .pc_plus2(pc_plus2),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
    logic [2:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_pc;
  logic [2:0]  m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Condition table with the flags as plain booleans.
  function automatic bit taken_model(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    branch = 1'b0; branch_reg = 1'b0; halt = 1'b0; cond = 3'd0;
    imm = 16'h0000; rs_data = 16'h0000; flag_wen = 3'd0; alu_flags = 3'd0;
  endtask

  task automatic check_reset_vals();
    check("rst_req",       32'(imem_req),    32'd0);
    check("rst_ivalid",    32'(instr_valid), 32'd0);
    check("rst_halted",    32'(halted),      32'd0);
    check("rst_fetch_err", 32'(fetch_err),   32'd0);
    check("rst_flags",     32'(flags),       32'd0);
    check("rst_instr",     32'(instr),       32'd0);
    check("rst_addr",      32'(imem_addr),   32'(RESET_PC));
    check("rst_pc_plus2",  32'(pc_plus2),    32'(RESET_PC + 16'd2));
  endtask

  // Hold reset for n cycles, then release and confirm IDLE -> FETCH at RESET_PC.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle_inputs();
    repeat (n) @(negedge clk);
    check_reset_vals();
    rst_n   = 1'b1;
    m_pc    = RESET_PC;
    m_flags = 3'b000;
    exp_q.delete();
    check("idle_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("first_req",  32'(imem_req),  32'd1);
    check("first_addr", 32'(imem_addr), 32'(RESET_PC));
  endtask

  task automatic run_instr(input logic [15:0] word, input int dly,
                           input logic br, input logic brr, input logic hlt,
                           input logic [2:0] cd, input logic [15:0] im, input logic [15:0] rs,
                           input logic [2:0] fwe, input logic [2:0] af);
    int guard;
    logic [15:0] nxt;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    for (int i = 0; i < dly; i++) begin
      check("req_held",    32'(imem_req),  32'd1);
      check("addr_stable", 32'(imem_addr), 32'(m_pc));
      @(negedge clk);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    exp_q.push_back('{word: word, pc: m_pc, flags: m_flags});
    @(negedge clk);
    check("exec_latency", 32'(instr_valid), 32'd1);
    // Memory noise during EXEC must be ignored.
    imem_valid = 1'($urandom);
    imem_rdata = 16'($urandom);
    branch = br; branch_reg = brr; halt = hlt; cond = cd;
    imm = im; rs_data = rs; flag_wen = fwe; alu_flags = af;
    if (!hlt) begin
      if (br && taken_model(cd, m_flags)) nxt = brr ? (rs & 16'hFFFE) : 16'(m_pc + 16'd2 + im);
      else                                nxt = 16'(m_pc + 16'd2);
      for (int i = 0; i < 3; i++) if (fwe[i]) m_flags[i] = af[i];
      m_pc = nxt;
    end
    @(negedge clk);
    idle_inputs();
    check("post_exec_req", 32'(imem_req), 32'(!hlt));
    check("post_halted",   32'(halted),   32'(hlt));
  endtask

  task automatic check_parked(input string tag, input logic [15:0] pc, input logic err);
    repeat (4) begin
      check({tag, "_req"},    32'(imem_req),    32'd0);
      check({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
      check({tag, "_addr"},   32'(imem_addr),   32'(pc));
      check({tag, "_halted"}, 32'(halted),      32'd1);
      check({tag, "_err"},    32'(fetch_err),   32'(err));
      @(negedge clk);
    end
  endtask

  // Monitor: every EXEC cycle pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_exec", 32'(instr_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr",    32'(instr),     32'(e.word));
        check("pc",       32'(imem_addr), 32'(e.pc));
        check("pc_plus2", 32'(pc_plus2),  32'(16'(e.pc + 16'd2)));
        check("flags",    32'(flags),     32'(e.flags));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Directed: zero-wait, delayed fetch, flag merge, branches, wrap, BR, halt.
    do_reset(2);
    run_instr(16'h0123, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 3'b111, 3'b010);
    run_instr(16'h1111, 3, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 3'b100, 3'b111);
    run_instr(16'h2222, 0, 1, 0, 0, 3'd1, 16'h0008, 16'h0000, 3'b000, 3'b000);
    run_instr(16'h3333, 1, 1, 1, 0, 3'd7, 16'h0000, 16'h0010, 3'b000, 3'b000);
    run_instr(16'h4444, 0, 1, 0, 0, 3'd1, 16'hFFFC, 16'h0000, 3'b000, 3'b000);
    run_instr(16'h5555, 0, 1, 1, 0, 3'd7, 16'h0000, 16'h0010, 3'b000, 3'b000);
    run_instr(16'h6666, 2, 1, 0, 0, 3'd0, 16'hFFFC, 16'h0000, 3'b000, 3'b000);
    run_instr(16'h7777, 0, 1, 1, 0, 3'd7, 16'h0000, 16'hFFFC, 3'b000, 3'b000);
    run_instr(16'h8888, 0, 1, 0, 0, 3'd7, 16'h0004, 16'h0000, 3'b000, 3'b000);
    run_instr(16'h9999, 0, 1, 1, 0, 3'd7, 16'h0000, 16'h1235, 3'b000, 3'b000);
    run_instr(16'hAAAA, 0, 1, 1, 0, 3'd6, 16'h0000, 16'h4000, 3'b010, 3'b000);
    run_instr(16'hBBBB, 0, 1, 1, 0, 3'd6, 16'h0000, 16'h5000, 3'b000, 3'b000);
    run_instr(16'hCCCC, 0, 1, 1, 0, 3'd7, 16'h0000, 16'h0040, 3'b000, 3'b000);
    run_instr(16'hDDDD, 1, 1, 0, 1, 3'd7, 16'h0100, 16'h0000, 3'b111, 3'b000);
    check("halt_flags", 32'(flags), 32'(m_flags));
    check_parked("halt", 16'h0040, 1'b0);

    // Random instruction stream, ending in a halt.
    do_reset(1);
    for (int k = 0; k < 150; k++) begin
      run_instr(16'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'b0, 3'($urandom),
                16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    end
    run_instr(16'hF00D, 0, 1'($urandom), 1'($urandom), 1'b1, 3'($urandom),
              16'($urandom), 16'($urandom), 3'b111, 3'($urandom));
    check("rand_halt_flags", 32'(flags), 32'(m_flags));
    check_parked("rand_halt", m_pc, 1'b0);

    // Fetch timeout: memory never answers.
    do_reset(1);
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 50) begin
      check("to_addr", 32'(imem_addr), 32'(RESET_PC));
      cnt++;
      @(negedge clk);
    end
    check("to_fetch_cycles", 32'(cnt), 32'(MAX_WAIT));
    check_parked("timeout", RESET_PC, 1'b1);

    // One-cycle reset in the middle of a fetch, after some progress.
    do_reset(1);
    run_instr(16'h0A0A, 0, 1, 1, 0, 3'd7, 16'h0000, 16'h0200, 3'b101, 3'b101);
    repeat (2) @(negedge clk);
    check("mid_fetch_req", 32'(imem_req), 32'd1);
    do_reset(1);
    run_instr(16'h0B0B, 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 3'b000);
    run_instr(16'h0C0C, 0, 1, 0, 0, 3'd2, 16'h0010, 16'h0000, 3'b000, 3'b000);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Front end of the 16-bit single-cycle CPU. Holds the PC and fetches instructions from a variable-latency instruction memory.
- Presents each fetched instruction to the control decoder for one execute cycle.
- Consumes the decoder's Branch/BranchRegister/Halt signals, the condition field, the immediate and the rs data, then computes the next PC.
- Owns the Z/V/N flag register used for condition evaluation.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
MAX_WAIT, 8, consecutive FETCH cycles without imem_valid before the fetch is declared failed (legal range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
imem_addr  out  16  fetch byte address (= pc)
imem_req  out  1  fetch request, high only in FETCH
imem_rdata  in  16  instruction word
imem_valid  in  1  imem_rdata valid this cycle
instr  out  16  latched instruction to decoder
instr_valid  out  1  high for exactly the EXEC cycle of each instruction
branch  in  1  decoder Branch
branch_reg  in  1  decoder BranchRegister
halt  in  1  decoder HLT
cond  in  3  decoder cond field
imm  in  16  decoder sign-extended, pre-shifted branch offset
rs_data  in  16  register-file read of rs (BR target)
flag_wen  in  3  per-flag write enable {Z,V,N}
alu_flags  in  3  ALU result flags {Z,V,N}
flags  out  3  current {Z,V,N}
pc_plus2  out  16  pc+2 (PCS write-back value), combinational
halted  out  1  processor stopped
fetch_err  out  1  sticky, set on fetch timeout

Behaviour:
- Synchronous reset, sampled on rising clk, overrides every other event including mid-fetch and mid-EXEC.
- Reset values: pc=RESET_PC, state=IDLE, instr=16'h0000, flags=3'b000, wait counter=0, halted=0, fetch_err=0, imem_req=0, instr_valid=0.
- States and transitions:
  - IDLE: go to FETCH on the next edge.
  - FETCH: imem_req=1, imem_addr=pc. If imem_valid is high this cycle, latch imem_rdata into instr, clear the counter, go to EXEC (zero-wait memory supported; one-cycle request-to-execute minimum). Otherwise increment the counter. When the counter reaches MAX_WAIT, set fetch_err=1 and halted=1, go to HALTED; pc is unchanged.
  - EXEC: instr_valid=1, imem_req=0.
    - If halt=1: go to HALTED, set halted=1, pc holds the HLT address, flags are not written.
    - Otherwise pc<=next_pc, flags[i]<=alu_flags[i] for each flag_wen[i]=1, go to FETCH.
  - HALTED: imem_req=0, instr_valid=0. Stays until reset.
- imem_valid is ignored outside FETCH.
- Condition taken (evaluated with the flags held at the start of EXEC, i.e. before this instruction's flag write):
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0 and N=0
  - 011 N=1
  - 100 Z=1 or (Z=0 and N=0)
  - 101 N=1 or Z=1
  - 110 V=1
  - 111 always
- next_pc:
  - branch=0 or not taken: pc+2.
  - branch=1, branch_reg=0, taken: pc+2+imm.
  - branch=1, branch_reg=1, taken: rs_data with bit 0 forced to 0.
  - All sums are 16-bit modulo 2^16 (0xFFFE+2 wraps to 0x0000); no carry out.
- pc_plus2 = pc+2 (mod 2^16), valid in every state.
- branch and halt both high: halt wins.
- flag_wen nonzero together with halt: no flag write.

Test Plan:
- Reset then zero-wait memory returning 16'h0123 with branch=halt=0 -> imem_req high in the cycle after IDLE, instr=16'h0123 with instr_valid pulse, then pc=0x0002 and the next request at 0x0002; each instruction takes 2 cycles.
- Memory delays imem_valid by 3 cycles -> imem_req held high with imem_addr stable for 4 cycles, one instr_valid pulse; with MAX_WAIT=8 and imem_valid never asserted -> fetch_err=1, halted=1 after 8 FETCH cycles, pc unchanged.
- pc=0x0010, flags Z=1, branch=1, cond=001, imm=16'hFFFC -> pc=0x000E. Same with cond=000 -> pc=0x0012. Same with cond=111, imm=0x0004, pc=0xFFFC -> pc=0x0002 (wrap).
- BR taken with rs_data=16'h1235 -> pc=0x1234. BR with cond=110, V=0 -> pc+2.
- EXEC with flag_wen=3'b100, alu_flags=3'b111 -> flags become {1,old V,old N}. A branch in the following instruction uses the new Z.
- halt=1 at pc=0x0040 -> halted=1, pc stays 0x0040, no further imem_req. rst_n low for one cycle mid-FETCH -> all outputs at reset values, refetch from RESET_PC.
